// File: rtl/psum_acc_pkg.sv
// -----------------------------------------------------------------------------
// psum_acc_pkg
// Shared types and helpers for the partial-sum accumulation engine.
//   mode_e  : request opcode (WRITE, ACCUM, READ, NOP)
//   sat_add : signed saturating add of one lane.
//             Inputs are sign-extended to SAT_W bits. The result is clamped to
//             the range of a bw-bit signed value.
// Lane widths up to 32 bits are supported.
// -----------------------------------------------------------------------------
package psum_acc_pkg;

    typedef enum logic [1:0] {
        WRITE = 2'b00,
        ACCUM = 2'b01,
        READ  = 2'b10,
        NOP   = 2'b11
    } mode_e;

    // Wide enough that the sum of two sign-extended lanes can never wrap.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      bw
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (bw - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/psum_bank.sv
// -----------------------------------------------------------------------------
// psum_bank
// 1R1W synchronous row buffer with a 1-cycle read latency.
// The buffer holds 2**addr_w rows, each col*psum_bw bits wide.
// A read and a write to the same row in the same cycle return the old row.
// The engine forwards around this case.
// Ports:
//   clk             : clock
//   wr_en / wr_addr / wr_data : write port
//   rd_en / rd_addr : read request. rd_data updates only when rd_en is high.
//   rd_data         : registered read data, valid one cycle after rd_en
// -----------------------------------------------------------------------------
module psum_bank #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [addr_w-1:0]        wr_addr,
    input  logic [col*psum_bw-1:0]   wr_data,
    input  logic                     rd_en,
    input  logic [addr_w-1:0]        rd_addr,
    output logic [col*psum_bw-1:0]   rd_data
);

    localparam int row_w = col * psum_bw;

    logic [row_w-1:0] mem [2**addr_w];

    // NOTE: the storage array has no reset, so it can map onto RAM macros.
    // Its contents after reset are simply undefined.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_acc_engine.sv
// -----------------------------------------------------------------------------
// psum_acc_engine
// Three-stage partial-sum engine built around a psum_bank row buffer.
//   S0 : accept the request and issue the buffer read
//   S1 : capture the read data, resolving forwarding
//   S2 : either write the new row, or load the output register
// The whole pipeline stalls while out_valid is held and out_ready is low.
// Optional build macro:
//   RELU_OUT_EN : READ output has negative lanes forced to zero.
//                 Stored rows are never modified by this option.
// Ports:
//   clk, reset     : clock, async active-low reset
//   in_valid/ready : request handshake
//   in_mode        : 00 WRITE, 01 ACCUM, 10 READ, 11 no-op
//   in_addr        : buffer row
//   in_data        : lane-packed psums, lane 0 at the LSBs
//   out_valid/ready/data : readout handshake and row
//   busy           : any stage or the output register holds an op
// -----------------------------------------------------------------------------
module psum_acc_engine
    import psum_acc_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [addr_w-1:0]        in_addr,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     busy
);

    localparam int row_w = col * psum_bw;

    logic               adv;
    logic               accept;

    // S1 stage
    logic               s1_valid;
    mode_e              s1_mode;
    logic [addr_w-1:0]  s1_addr;
    logic [row_w-1:0]   s1_din;
    logic               s1_fwd_hit;   // S2 wrote this row on the accept edge
    logic [row_w-1:0]   s1_fwd_data;
    logic [row_w-1:0]   s1_old;

    // S2 stage
    logic               s2_valid;
    mode_e              s2_mode;
    logic [addr_w-1:0]  s2_addr;
    logic [row_w-1:0]   s2_din;
    logic [row_w-1:0]   s2_old;
    logic               s2_wr;
    logic [row_w-1:0]   s2_result;
    logic [row_w-1:0]   acc_row;
    logic [row_w-1:0]   out_row;

    logic               bank_wr_en;
    logic [row_w-1:0]   bank_rd_data;

    assign adv        = !(out_valid && !out_ready);
    assign in_ready   = adv;
    assign accept     = in_valid && adv;
    assign s2_wr      = s2_valid && (s2_mode == WRITE || s2_mode == ACCUM);
    assign bank_wr_en = s2_wr && adv;
    assign busy       = s1_valid || s2_valid || out_valid;

    psum_bank #(
        .col     (col),
        .psum_bw (psum_bw),
        .addr_w  (addr_w)
    ) u_bank (
        .clk     (clk),
        .wr_en   (bank_wr_en),
        .wr_addr (s2_addr),
        .wr_data (s2_result),
        .rd_en   (accept),
        .rd_addr (in_addr),
        .rd_data (bank_rd_data)
    );

    // Per-lane saturating accumulate of the S2 row.
    always_comb begin
        // NOTE: give every comb output a default before any conditional
        // assignment, so that no path leaves it unassigned and infers a latch.
        acc_row = '0;
        for (int l = 0; l < col; l++) begin
            acc_row[l*psum_bw +: psum_bw] = psum_bw'(sat_add(
                SAT_W'($signed(s2_old[l*psum_bw +: psum_bw])),
                SAT_W'($signed(s2_din[l*psum_bw +: psum_bw])),
                psum_bw));
        end
    end

    assign s2_result = (s2_mode == ACCUM) ? acc_row : s2_din;

    // Choose the newest value of the S1 row. An S2 write in flight is the
    // youngest. Next is a write that landed on the accept edge, which the
    // bank read missed. Otherwise the bank data is current.
    always_comb begin
        s1_old = bank_rd_data;
        if (s2_wr && (s2_addr == s1_addr)) begin
            s1_old = s2_result;
        end else if (s1_fwd_hit) begin
            s1_old = s1_fwd_data;
        end
    end

    // Readout row. The ReLU only affects the output path, never the buffer.
    always_comb begin
        out_row = s2_old;
`ifdef RELU_OUT_EN
        for (int l = 0; l < col; l++) begin
            if (s2_old[l*psum_bw + psum_bw - 1]) begin
                out_row[l*psum_bw +: psum_bw] = '0;
            end
        end
`else
        // Raw signed row is passed through unchanged.
`endif
    end

    // NOTE: registers use non-blocking assignments, so every stage samples
    // the previous-cycle value of its upstream stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_mode     <= NOP;
            s1_addr     <= '0;
            s1_din      <= '0;
            s1_fwd_hit  <= 1'b0;
            s1_fwd_data <= '0;
            s2_valid    <= 1'b0;
            s2_mode     <= NOP;
            s2_addr     <= '0;
            s2_din      <= '0;
            s2_old      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else if (adv) begin
            s1_valid    <= accept;
            s1_mode     <= mode_e'(in_mode);
            s1_addr     <= in_addr;
            s1_din      <= in_data;
            s1_fwd_hit  <= bank_wr_en && (s2_addr == in_addr);
            s1_fwd_data <= s2_result;

            s2_valid    <= s1_valid;
            s2_mode     <= s1_mode;
            s2_addr     <= s1_addr;
            s2_din      <= s1_din;
            s2_old      <= s1_old;

            // adv implies the output register is empty or being consumed now.
            out_valid   <= s2_valid && (s2_mode == READ);
            if (s2_valid && (s2_mode == READ)) begin
                out_data <= out_row;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_engine.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_engine
// Self-checking bench for psum_acc_engine.
// The reference model is a plain row array updated in program order at
// request acceptance. READ expectations are queued and matched at each output
// handshake.
// Honours the RELU_OUT_EN build macro.
// -----------------------------------------------------------------------------
module tb_psum_acc_engine;
    import psum_acc_pkg::*;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int RW  = COL * BW;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_mode;
    logic [AW-1:0]  in_addr;
    logic [RW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  out_data;
    logic           busy;

    psum_acc_engine #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int             n_vectors;
    int             n_miscompares;
    int             n_out_hs;
    int             n_cyc;
    logic [RW-1:0]  model_mem [2**AW];
    logic [RW-1:0]  exp_q [$];

    logic           drv_valid;
    logic [1:0]     drv_mode;
    logic [AW-1:0]  drv_addr;
    logic [RW-1:0]  drv_data;

    logic           last_acc;
    logic           last_ov;
    logic           last_rdy;
    logic [RW-1:0]  last_od;
    logic [RW-1:0]  last_rd;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] splat(input int v);
        logic [RW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [RW-1:0] lane_row(input int lane, input int v);
        logic [RW-1:0] r;
        r = '0;
        r[lane*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Per-lane signed add, clamped to the signed lane range.
    function automatic logic [RW-1:0] accum_ref(input logic [RW-1:0] old_row, input logic [RW-1:0] add_row);
        logic [RW-1:0] r;
        int hi;
        int lo;
        int s;
        hi = (1 << (BW - 1)) - 1;
        lo = -(1 << (BW - 1));
        for (int l = 0; l < COL; l++) begin
            s = int'($signed(old_row[l*BW +: BW])) + int'($signed(add_row[l*BW +: BW]));
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            r[l*BW +: BW] = BW'(s);
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] relu_ref(input logic [RW-1:0] row);
        logic [RW-1:0] r;
        r = row;
`ifdef RELU_OUT_EN
        for (int l = 0; l < COL; l++) begin
            if (int'($signed(row[l*BW +: BW])) < 0) r[l*BW +: BW] = '0;
        end
`endif
        return r;
    endfunction

    task automatic model_apply(input logic [1:0] m, input logic [AW-1:0] a, input logic [RW-1:0] d);
        if (m == WRITE)      model_mem[a] = d;
        else if (m == ACCUM) model_mem[a] = accum_ref(model_mem[a], d);
        else if (m == READ)  exp_q.push_back(relu_ref(model_mem[a]));
    endtask

    // One clock cycle. Called at a negedge, samples at +1, returns at the next negedge.
    task automatic cycle();
        in_valid = drv_valid;
        in_mode  = drv_mode;
        in_addr  = drv_addr;
        in_data  = drv_data;
        #1;
        last_acc = in_valid && in_ready;
        last_ov  = out_valid;
        last_rdy = in_ready;
        last_od  = out_data;
        if (out_valid && out_ready) begin
            n_out_hs++;
            last_rd = out_data;
            if (exp_q.size() == 0) check("spurious_out_valid", RW'(out_valid), '0);
            else                   check("rd_data", out_data, exp_q.pop_front());
        end
        if (last_acc) model_apply(drv_mode, drv_addr, drv_data);
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic issue(input logic [1:0] m, input logic [AW-1:0] a, input logic [RW-1:0] d);
        int tries;
        drv_valid = 1'b1;
        drv_mode  = m;
        drv_addr  = a;
        drv_data  = d;
        tries = 0;
        do begin
            cycle();
            tries++;
        end while (!last_acc && tries < 64);
        if (!last_acc) check("accept_timeout", RW'(last_acc), RW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start;
        int hs0;
        int waited;
        logic [RW-1:0] hold;

        n_vectors = 0; n_miscompares = 0; n_out_hs = 0; n_cyc = 0;
        drv_valid = 0; drv_mode = 2'b00; drv_addr = '0; drv_data = '0;
        in_valid = 0; in_mode = 2'b00; in_addr = '0; in_data = '0;
        out_ready = 1'b1; last_rd = '0;
        reset = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", RW'(out_valid), '0);
        check("rst_busy", RW'(busy), '0);
        check("rst_out_data", out_data, '0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", RW'(in_ready), RW'(1));

        // WRITE then READ, with the read latency measured
        issue(WRITE, 5, splat(100));
        issue(READ, 5, '0);
        drv_valid = 1'b0;
        cycle(); check("lat_cycle1_ov", RW'(last_ov), '0);
        cycle(); check("lat_cycle2_ov", RW'(last_ov), '0);
        cycle(); check("lat_cycle3_ov", RW'(last_ov), RW'(1));
        check("read5_data", last_rd, splat(100));

        // Back-to-back ACCUMs rely on forwarding; throughput is one op per cycle
        start = n_cyc;
        issue(WRITE, 3, splat(0));
        issue(ACCUM, 3, splat(1));
        issue(ACCUM, 3, splat(2));
        issue(ACCUM, 3, splat(3));
        issue(READ, 3, '0);
        check("throughput_cycles", RW'(n_cyc - start), RW'(5));
        idle(4);
        check("fwd_accum", last_rd, splat(6));

        // Saturation at both ends
        issue(WRITE, 7, lane_row(0, 32760));
        issue(ACCUM, 7, lane_row(0, 100));
        issue(READ, 7, '0);
        idle(4);
        check("sat_pos", last_rd, lane_row(0, 32767));
        issue(WRITE, 7, lane_row(0, -32760));
        issue(ACCUM, 7, lane_row(0, -100));
        issue(READ, 7, '0);
        idle(4);
`ifdef RELU_OUT_EN
        check("sat_neg", last_rd, '0);
`else
        check("sat_neg", last_rd, lane_row(0, -32768));
`endif

        // Output stall: hold for 5 cycles, then exactly one handshake
        issue(WRITE, 9, splat(1234));
        issue(READ, 9, '0);
        drv_valid = 1'b0;
        out_ready = 1'b0;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (!last_ov && waited < 10);
        check("stall_out_valid_seen", RW'(last_ov), RW'(1));
        hold = last_od;
        check("stall_first_data", hold, splat(1234));
        hs0 = n_out_hs;
        drv_valid = 1'b1; drv_mode = WRITE; drv_addr = 10; drv_data = splat(55);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_in_ready", RW'(last_rdy), '0);
            check("stall_out_data", last_od, hold);
            check("stall_out_valid", RW'(last_ov), RW'(1));
        end
        out_ready = 1'b1;
        cycle();
        check("stall_accept_on_release", RW'(last_acc), RW'(1));
        drv_valid = 1'b0;
        cycle();
        check("stall_one_handshake", RW'(n_out_hs - hs0), RW'(1));
        check("stall_ov_cleared", RW'(last_ov), '0);
        idle(3);

        // Negative lane through the output path
        issue(WRITE, 11, lane_row(2, -7));
        issue(READ, 11, '0);
        idle(4);
`ifdef RELU_OUT_EN
        check("relu_lane2", RW'(last_rd[2*BW +: BW]), '0);
`else
        check("relu_lane2", RW'(last_rd[2*BW +: BW]), RW'(16'hFFF9));
`endif

        // Reset while an ACCUM sits stalled in S2 behind a held READ
        issue(WRITE, 12, splat(50));
        idle(4);
        out_ready = 1'b0;
        issue(READ, 12, '0);
        issue(ACCUM, 12, splat(1));
        idle(3);
        check("pre_rst_busy", RW'(busy), RW'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", RW'(out_valid), '0);
        check("mid_rst_busy", RW'(busy), '0);
        check("mid_rst_out_data", out_data, '0);
        // The in-flight ops are dropped, so the model row keeps its pre-ACCUM value.
        exp_q.delete();
        model_mem[12] = splat(50);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        issue(READ, 12, '0);
        idle(4);
        check("no_partial_write", last_rd, relu_ref(splat(50)));

        // Randomized traffic on a small address window to stress forwarding
        for (int a = 0; a < 16; a++) issue(WRITE, AW'(a), rand_row());
        for (int i = 0; i < 800; i++) begin
            drv_valid = ($urandom_range(0, 9) < 8);
            drv_mode  = 2'($urandom_range(0, 3));
            drv_addr  = AW'($urandom_range(0, 15));
            drv_data  = rand_row();
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        out_ready = 1'b1;
        idle(6);
        check("drain_queue_empty", RW'(exp_q.size()), '0);
        check("drain_busy", RW'(busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
